// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared defines for the execute stage and the load/store unit.
// Contents:
//   - ls_info one-hot bit positions (11-bit vector from decode)
//   - load-only slice positions, used by the load formatter
//   - LSU FSM state encoding
//   - access size codes and helpers for size and offset-mask lookup
// -----------------------------------------------------------------------------
package lsu_pkg;

  localparam int LS_INFO_W = 11;
  localparam int LS_LB     = 10;
  localparam int LS_LH     = 9;
  localparam int LS_LW     = 8;
  localparam int LS_LD     = 7;
  localparam int LS_LBU    = 6;
  localparam int LS_LHU    = 5;
  localparam int LS_LWU    = 4;
  localparam int LS_SB     = 3;
  localparam int LS_SH     = 2;
  localparam int LS_SW     = 1;
  localparam int LS_SD     = 0;

  // The load bits [10:4] are carried as a 7-bit slice; LD_BASE re-bases them.
  localparam int LD_INFO_W = 7;
  localparam int LD_BASE   = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } lsu_state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  // log2 of the access size in bytes; an empty ls_info reads as a doubleword.
  function automatic logic [1:0] access_size(input logic [LS_INFO_W-1:0] info);
    logic [1:0] s;
    s = SIZE_D;
    if (info[LS_LB] | info[LS_LBU] | info[LS_SB])
      s = SIZE_B;
    else if (info[LS_LH] | info[LS_LHU] | info[LS_SH])
      s = SIZE_H;
    else if (info[LS_LW] | info[LS_LWU] | info[LS_SW])
      s = SIZE_W;
    else if (info[LS_LD] | info[LS_SD])
      s = SIZE_D;
    return s;
  endfunction

  // Offset bits that must be zero for a naturally aligned access of this size.
  function automatic logic [2:0] offset_mask(input logic [1:0] size);
    logic [2:0] m;
    m = 3'b111 << size;
    return ~m;
  endfunction

endpackage

// File: rtl/lsu_ldfmt.sv
// -----------------------------------------------------------------------------
// lsu_ldfmt
// Combinational load formatter: moves the addressed bytes of the returned
// doubleword down to bit 0, then sign- or zero-extends by load type.
// Ports:
//   rdata   in  XLEN  aligned doubleword from data memory
//   off     in  3     byte offset within the doubleword
//   ld_info in  7     load one-hot slice {lb,lh,lw,ld,lbu,lhu,lwu}
//   data    out XLEN  formatted load result
// -----------------------------------------------------------------------------
module lsu_ldfmt
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0]      rdata,
  input  logic [2:0]           off,
  input  logic [LD_INFO_W-1:0] ld_info,
  output logic [XLEN-1:0]      data
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata >> {off, 3'b000};

  // Select the extension for the one active load bit; ld passes through.
  always_comb begin
    data = shifted;
    if (ld_info[LS_LB - LD_BASE])
      data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
    else if (ld_info[LS_LH - LD_BASE])
      data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
    else if (ld_info[LS_LW - LD_BASE])
      data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
    else if (ld_info[LS_LBU - LD_BASE])
      data = {{(XLEN-8){1'b0}}, shifted[7:0]};
    else if (ld_info[LS_LHU - LD_BASE])
      data = {{(XLEN-16){1'b0}}, shifted[15:0]};
    else if (ld_info[LS_LWU - LD_BASE])
      data = {{(XLEN-32){1'b0}}, shifted[31:0]};
    else if (ld_info[LS_LD - LD_BASE])
      data = shifted;
  end

endmodule

// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu
// Load/store unit between execute and writeback. Non-memory ops pass through
// with one cycle of latency; loads and stores issue one data-memory request
// and wait for its ack. The unit accepts a new op only in IDLE (o_ready).
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   i_valid .. i_mem_write        execute-side op (rd result, address, data,
//                                 one-hot ls_info, load/store flags)
//   o_ready                       high when a new op can be accepted
//   o_dmem_*, i_dmem_ack/rdata    data-memory request/response
//   o_valid, o_rd_*               writeback result (o_rd_data also forwards)
//   o_misalign                    misaligned-access flag (only with macro)
// Configuration macro: LSU_MISALIGN_CHK_EN
//   defined   - misaligned accesses skip memory and finish with o_misalign=1
//   undefined - the offset is truncated to the access size and the access runs
// -----------------------------------------------------------------------------
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic [XLEN-1:0]      i_rd_data,
  input  logic                 i_rd_wen,
  input  logic [4:0]           i_rd_addr,
  input  logic [XLEN-1:0]      i_mem_addr,
  input  logic [XLEN-1:0]      i_mem_wdata,
  input  logic [LS_INFO_W-1:0] i_ls_info,
  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  output logic                 o_ready,
  output logic                 o_dmem_req,
  output logic                 o_dmem_we,
  output logic [XLEN-1:0]      o_dmem_addr,
  output logic [XLEN-1:0]      o_dmem_wdata,
  output logic [7:0]           o_dmem_wmask,
  input  logic                 i_dmem_ack,
  input  logic [XLEN-1:0]      i_dmem_rdata,
  output logic                 o_valid,
  output logic                 o_rd_wen,
  output logic [4:0]           o_rd_addr,
  output logic [XLEN-1:0]      o_rd_data
`ifdef LSU_MISALIGN_CHK_EN
  ,
  output logic                 o_misalign
`endif
);

  lsu_state_e           state, state_nxt;
  logic                 accept, is_mem, is_store, is_load, misalign_now;
  logic [1:0]           size;
  logic [2:0]           off_raw, off_eff, off_q;
  logic [7:0]           wmask_new;
  logic [XLEN-1:0]      wdata_new, ld_data;
  logic                 rd_wen_q, is_load_q;
  logic [LD_INFO_W-1:0] ld_info_q;

  assign accept   = (state == S_IDLE) & i_valid;
  assign is_mem   = i_mem_read | i_mem_write;
  // Read and write together is a store.
  assign is_store = i_mem_write;
  assign is_load  = i_mem_read & ~i_mem_write;
  assign size     = access_size(i_ls_info);
  assign off_raw  = i_mem_addr[2:0];

`ifdef LSU_MISALIGN_CHK_EN
  assign misalign_now = is_mem & (|(off_raw & offset_mask(size)));
  assign off_eff      = off_raw;
`else
  assign misalign_now = 1'b0;
  assign off_eff      = off_raw & ~offset_mask(size);
`endif

  // Byte strobes follow the access size; loads never strobe.
  always_comb begin
    wmask_new = 8'h00;
    if (is_store) begin
      case (size)
        SIZE_B:  wmask_new = 8'h01 << off_eff;
        SIZE_H:  wmask_new = 8'h03 << off_eff;
        SIZE_W:  wmask_new = 8'h0F << off_eff;
        default: wmask_new = 8'hFF;
      endcase
    end
  end

  assign wdata_new = is_store ? (i_mem_wdata << {off_eff, 3'b000}) : '0;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Next state: memory ops wait in REQ for ack; everything else goes to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (i_valid)
          state_nxt = (is_mem && !misalign_now) ? S_REQ : S_DONE;
      end
      S_REQ: begin
        if (i_dmem_ack)
          state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign o_ready  = (state == S_IDLE);
  assign o_valid  = (state == S_DONE);
  assign o_rd_wen = rd_wen_q & o_valid;

  // Op capture at accept, request hold in REQ, and load result capture on ack.
  // The request registers are cleared asynchronously so a reset in REQ
  // abandons the access immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_dmem_req   <= 1'b0;
      o_dmem_we    <= 1'b0;
      o_dmem_addr  <= '0;
      o_dmem_wdata <= '0;
      o_dmem_wmask <= 8'h00;
      o_rd_addr    <= 5'd0;
      o_rd_data    <= '0;
      rd_wen_q     <= 1'b0;
      is_load_q    <= 1'b0;
      off_q        <= 3'd0;
      ld_info_q    <= '0;
    end else begin
      if (accept) begin
        o_rd_addr <= i_rd_addr;
        off_q     <= off_eff;
        ld_info_q <= i_ls_info[LS_INFO_W-1:LD_BASE];
        is_load_q <= is_load & ~misalign_now;
        if (!is_mem) begin
          o_rd_data <= i_rd_data;
          rd_wen_q  <= i_rd_wen;
        end else if (misalign_now) begin
          rd_wen_q  <= 1'b0;
        end else begin
          o_dmem_req   <= 1'b1;
          o_dmem_we    <= is_store;
          o_dmem_addr  <= {i_mem_addr[XLEN-1:3], 3'b000};
          o_dmem_wdata <= wdata_new;
          o_dmem_wmask <= wmask_new;
          rd_wen_q     <= i_rd_wen & ~is_store;
        end
      end
      if ((state == S_REQ) && i_dmem_ack) begin
        o_dmem_req <= 1'b0;
        o_dmem_we  <= 1'b0;
        if (is_load_q)
          o_rd_data <= ld_data;
      end
    end
  end

`ifdef LSU_MISALIGN_CHK_EN
  logic misalign_q;

  // Misalign flag for the current op, shown only while the result is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      misalign_q <= 1'b0;
    else if (accept)
      misalign_q <= misalign_now;
  end

  assign o_misalign = misalign_q & o_valid;
`endif

  lsu_ldfmt #(.XLEN(XLEN)) u_ldfmt (
    .rdata   (i_dmem_rdata),
    .off     (off_q),
    .ld_info (ld_info_q),
    .data    (ld_data)
  );

endmodule

// File: tb/tb_lsu.sv
// -----------------------------------------------------------------------------
// tb_lsu
// Directed testbench for lsu. Expected memory requests and writeback results
// are queued when each op is issued; a memory responder and a writeback
// monitor pop and compare as the DUT presents them.
// -----------------------------------------------------------------------------
module tb_lsu;

  localparam logic [10:0] LB  = 11'b100_0000_0000;
  localparam logic [10:0] LH  = 11'b010_0000_0000;
  localparam logic [10:0] LW  = 11'b001_0000_0000;
  localparam logic [10:0] LD  = 11'b000_1000_0000;
  localparam logic [10:0] LBU = 11'b000_0100_0000;
  localparam logic [10:0] LHU = 11'b000_0010_0000;
  localparam logic [10:0] LWU = 11'b000_0001_0000;
  localparam logic [10:0] SB  = 11'b000_0000_1000;
  localparam logic [10:0] SH  = 11'b000_0000_0100;
  localparam logic [10:0] SW  = 11'b000_0000_0010;
  localparam logic [10:0] SD  = 11'b000_0000_0001;

  typedef struct {
    string       tag;
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic        chk_wdata;
    logic [7:0]  wmask;
    logic [63:0] rdata;
    int          delay;
  } req_t;

  typedef struct {
    string       tag;
    logic        rd_wen;
    logic [4:0]  rd_addr;
    logic        chk_data;
    logic [63:0] rd_data;
    logic        misalign;
  } wb_t;

  logic        clk, rst;
  logic        i_valid, i_rd_wen, i_mem_read, i_mem_write;
  logic [63:0] i_rd_data, i_mem_addr, i_mem_wdata;
  logic [4:0]  i_rd_addr;
  logic [10:0] i_ls_info;
  logic        o_ready, o_dmem_req, o_dmem_we;
  logic [63:0] o_dmem_addr, o_dmem_wdata;
  logic [7:0]  o_dmem_wmask;
  logic        i_dmem_ack;
  logic [63:0] i_dmem_rdata;
  logic        o_valid, o_rd_wen;
  logic [4:0]  o_rd_addr;
  logic [63:0] o_rd_data;
`ifdef LSU_MISALIGN_CHK_EN
  logic        o_misalign;
`endif

  int   num_checks = 0;
  int   num_fails  = 0;
  req_t req_q[$];
  wb_t  wb_q[$];
  logic inject_ack = 1'b0;

  lsu #(.XLEN(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .i_rd_data    (i_rd_data),
    .i_rd_wen     (i_rd_wen),
    .i_rd_addr    (i_rd_addr),
    .i_mem_addr   (i_mem_addr),
    .i_mem_wdata  (i_mem_wdata),
    .i_ls_info    (i_ls_info),
    .i_mem_read   (i_mem_read),
    .i_mem_write  (i_mem_write),
    .o_ready      (o_ready),
    .o_dmem_req   (o_dmem_req),
    .o_dmem_we    (o_dmem_we),
    .o_dmem_addr  (o_dmem_addr),
    .o_dmem_wdata (o_dmem_wdata),
    .o_dmem_wmask (o_dmem_wmask),
    .i_dmem_ack   (i_dmem_ack),
    .i_dmem_rdata (i_dmem_rdata),
    .o_valid      (o_valid),
    .o_rd_wen     (o_rd_wen),
    .o_rd_addr    (o_rd_addr),
    .o_rd_data    (o_rd_data)
`ifdef LSU_MISALIGN_CHK_EN
    ,
    .o_misalign   (o_misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic expectReq(input string tag, input logic [63:0] addr,
                           input logic we, input logic [63:0] wdata,
                           input logic chk_wdata, input logic [7:0] wmask,
                           input logic [63:0] rdata, input int delay);
    req_t r;
    r.tag = tag; r.addr = addr; r.we = we; r.wdata = wdata;
    r.chk_wdata = chk_wdata; r.wmask = wmask; r.rdata = rdata; r.delay = delay;
    req_q.push_back(r);
  endtask

  task automatic expectWb(input string tag, input logic rd_wen,
                          input logic [4:0] rd_addr, input logic chk_data,
                          input logic [63:0] rd_data, input logic misalign);
    wb_t w;
    w.tag = tag; w.rd_wen = rd_wen; w.rd_addr = rd_addr;
    w.chk_data = chk_data; w.rd_data = rd_data; w.misalign = misalign;
    wb_q.push_back(w);
  endtask

  // Call at a negedge. Waits for o_ready, issues one op, then (if exp_busy is
  // not negative) counts the cycles o_ready stays low afterwards.
  task automatic applyStimulus(input string tag, input logic [10:0] info,
                               input logic rd, input logic wr,
                               input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [63:0] rdv, input logic wen,
                               input logic [4:0] rdi, input int exp_busy);
    int n;
    n = 0;
    while (!o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) checkOutput({tag, ".ready_timeout"}, 64'd1, 64'd0);
    i_valid = 1'b1; i_ls_info = info; i_mem_read = rd; i_mem_write = wr;
    i_mem_addr = addr; i_mem_wdata = wdata; i_rd_data = rdv;
    i_rd_wen = wen; i_rd_addr = rdi;
    @(posedge clk);
    #1;
    i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0; i_ls_info = '0;
    if (exp_busy >= 0) begin
      n = 0;
      @(negedge clk);
      while (!o_ready && n < 100) begin
        n++;
        @(negedge clk);
      end
      checkOutput({tag, ".busy_cycles"}, 64'(n), 64'(exp_busy));
    end
  endtask

  // Memory responder: checks each request against the queue and acks after
  // the per-request number of cycles the request has been held.
  initial begin : responder
    req_t cur;
    int   req_cycles;
    logic have_req, skip;
    i_dmem_ack = 1'b0; i_dmem_rdata = '0;
    req_cycles = 0; have_req = 1'b0; skip = 1'b0;
    cur.tag = "none"; cur.delay = 1; cur.rdata = '0;
    forever begin
      @(negedge clk);
      i_dmem_ack = inject_ack;
      if (rst || !o_dmem_req) begin
        have_req = 1'b0;
        req_cycles = 0;
      end else begin
        if (!have_req) begin
          have_req = 1'b1;
          if (req_q.size() == 0) begin
            num_checks++; num_fails++;
            $display("[TB] FAIL unexpected_dmem_req: got req at addr 0x%h, expected none",
                     o_dmem_addr);
            skip = 1'b1; cur.delay = 1; cur.rdata = '0;
          end else begin
            skip = 1'b0;
            cur = req_q.pop_front();
          end
        end
        req_cycles++;
        if (!skip) begin
          checkOutput({cur.tag, ".dmem_addr"}, o_dmem_addr, cur.addr);
          checkOutput({cur.tag, ".dmem_we"}, o_dmem_we, cur.we);
          checkOutput({cur.tag, ".dmem_wmask"}, o_dmem_wmask, cur.wmask);
          if (cur.chk_wdata)
            checkOutput({cur.tag, ".dmem_wdata"}, o_dmem_wdata, cur.wdata);
        end
        if (req_cycles >= cur.delay) begin
          i_dmem_ack = 1'b1;
          i_dmem_rdata = cur.rdata;
        end
      end
    end
  end

  // Writeback monitor.
  initial begin : monitor
    wb_t e;
    forever begin
      @(negedge clk);
      if (!rst && o_valid) begin
        if (wb_q.size() == 0) begin
          num_checks++; num_fails++;
          $display("[TB] FAIL unexpected_valid: got o_valid=1 rd=%0d, expected no writeback",
                   o_rd_addr);
        end else begin
          e = wb_q.pop_front();
          checkOutput({e.tag, ".rd_wen"}, o_rd_wen, e.rd_wen);
          if (e.chk_data) begin
            checkOutput({e.tag, ".rd_addr"}, o_rd_addr, e.rd_addr);
            checkOutput({e.tag, ".rd_data"}, o_rd_data, e.rd_data);
          end
`ifdef LSU_MISALIGN_CHK_EN
          checkOutput({e.tag, ".misalign"}, o_misalign, e.misalign);
`endif
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b1; i_valid = 1'b0; i_rd_data = '0; i_rd_wen = 1'b0; i_rd_addr = '0;
    i_mem_addr = '0; i_mem_wdata = '0; i_ls_info = '0;
    i_mem_read = 1'b0; i_mem_write = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset.ready", o_ready, 1'b1);
    checkOutput("reset.dmem_req", o_dmem_req, 1'b0);
    checkOutput("reset.dmem_we", o_dmem_we, 1'b0);
    checkOutput("reset.dmem_addr", o_dmem_addr, 64'd0);
    checkOutput("reset.dmem_wdata", o_dmem_wdata, 64'd0);
    checkOutput("reset.dmem_wmask", o_dmem_wmask, 8'h00);
    checkOutput("reset.valid", o_valid, 1'b0);
    checkOutput("reset.rd_wen", o_rd_wen, 1'b0);
    checkOutput("reset.rd_addr", o_rd_addr, 5'd0);
    checkOutput("reset.rd_data", o_rd_data, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    expectWb("alu", 1'b1, 5'd5, 1'b1, 64'h1234, 1'b0);
    applyStimulus("alu", '0, 0, 0, 64'h0, 64'h0, 64'h1234, 1, 5'd5, 1);

    expectReq("lb", 64'h1000, 0, 64'h0, 0, 8'h00, 64'h00000000_80000000, 3);
    expectWb("lb", 1'b1, 5'd7, 1'b1, 64'hFFFFFFFF_FFFFFF80, 1'b0);
    applyStimulus("lb", LB, 1, 0, 64'h1003, 64'h0, 64'h0, 1, 5'd7, 4);

    expectReq("lbu", 64'h1000, 0, 64'h0, 0, 8'h00, 64'h00000000_80000000, 3);
    expectWb("lbu", 1'b1, 5'd8, 1'b1, 64'h80, 1'b0);
    applyStimulus("lbu", LBU, 1, 0, 64'h1003, 64'h0, 64'h0, 1, 5'd8, 4);

    expectReq("sh", 64'h2000, 1, 64'hBEEF0000_00000000, 1, 8'hC0, 64'h0, 2);
    expectWb("sh", 1'b0, 5'd9, 1'b0, 64'h0, 1'b0);
    applyStimulus("sh", SH, 0, 1, 64'h2006, 64'hBEEF, 64'h0, 1, 5'd9, 3);

`ifdef LSU_MISALIGN_CHK_EN
    expectWb("lw_mis", 1'b0, 5'd10, 1'b0, 64'h0, 1'b1);
    applyStimulus("lw_mis", LW, 1, 0, 64'h3002, 64'h0, 64'h0, 1, 5'd10, 1);
`else
    expectReq("lw_mis", 64'h3000, 0, 64'h0, 0, 8'h00, 64'h11111111_89ABCDEF, 2);
    expectWb("lw_mis", 1'b1, 5'd10, 1'b1, 64'hFFFFFFFF_89ABCDEF, 1'b0);
    applyStimulus("lw_mis", LW, 1, 0, 64'h3002, 64'h0, 64'h0, 1, 5'd10, 3);
`endif

    expectReq("lhu", 64'h4000, 0, 64'h0, 0, 8'h00, 64'hBEEF0000_00000000, 1);
    expectWb("lhu", 1'b1, 5'd11, 1'b1, 64'h0000_BEEF, 1'b0);
    applyStimulus("lhu", LHU, 1, 0, 64'h4006, 64'h0, 64'h0, 1, 5'd11, 2);

    expectReq("lh", 64'h4000, 0, 64'h0, 0, 8'h00, 64'hBEEF0000_00000000, 2);
    expectWb("lh", 1'b1, 5'd12, 1'b1, 64'hFFFFFFFF_FFFFBEEF, 1'b0);
    applyStimulus("lh", LH, 1, 0, 64'h4006, 64'h0, 64'h0, 1, 5'd12, 3);

    expectReq("sb", 64'h5000, 1, 64'h0000AB00_00000000, 1, 8'h20, 64'h0, 1);
    expectWb("sb", 1'b0, 5'd13, 1'b0, 64'h0, 1'b0);
    applyStimulus("sb", SB, 0, 1, 64'h5005, 64'hAB, 64'h0, 1, 5'd13, 2);

    expectReq("lwu", 64'h8000, 0, 64'h0, 0, 8'h00, 64'hF0000000_00000000, 2);
    expectWb("lwu", 1'b1, 5'd14, 1'b1, 64'h00000000_F0000000, 1'b0);
    applyStimulus("lwu", LWU, 1, 0, 64'h8004, 64'h0, 64'h0, 1, 5'd14, 3);

    expectReq("lb_pos", 64'h9000, 0, 64'h0, 0, 8'h00, 64'h00000000_00007F00, 1);
    expectWb("lb_pos", 1'b1, 5'd15, 1'b1, 64'h7F, 1'b0);
    applyStimulus("lb_pos", LB, 1, 0, 64'h9001, 64'h0, 64'h0, 1, 5'd15, 2);

    expectReq("rdwr_sd", 64'hA000, 1, 64'h55, 1, 8'hFF, 64'h0, 1);
    expectWb("rdwr_sd", 1'b0, 5'd16, 1'b0, 64'h0, 1'b0);
    applyStimulus("rdwr_sd", SD, 1, 1, 64'hA000, 64'h55, 64'h0, 1, 5'd16, 2);

    expectWb("alu_nowen", 1'b0, 5'd17, 1'b1, 64'hCAFE, 1'b0);
    applyStimulus("alu_nowen", '0, 0, 0, 64'h0, 64'h0, 64'hCAFE, 0, 5'd17, 1);

    // Back-to-back ops with the ack in the first REQ cycle.
    expectWb("b2b_alu0", 1'b1, 5'd1, 1'b1, 64'h1111, 1'b0);
    applyStimulus("b2b_alu0", '0, 0, 0, 64'h0, 64'h0, 64'h1111, 1, 5'd1, 1);
    expectReq("b2b_ld", 64'hC008, 0, 64'h0, 0, 8'h00, 64'h01234567_89ABCDEF, 1);
    expectWb("b2b_ld", 1'b1, 5'd2, 1'b1, 64'h01234567_89ABCDEF, 1'b0);
    applyStimulus("b2b_ld", LD, 1, 0, 64'hC008, 64'h0, 64'h0, 1, 5'd2, 2);
    expectReq("b2b_sw", 64'hD000, 1, 64'hDEADBEEF_00000000, 1, 8'hF0, 64'h0, 1);
    expectWb("b2b_sw", 1'b0, 5'd3, 1'b0, 64'h0, 1'b0);
    applyStimulus("b2b_sw", SW, 0, 1, 64'hD004, 64'hDEADBEEF, 64'h0, 1, 5'd3, 2);
    expectReq("b2b_sd", 64'hE000, 1, 64'h11223344_55667788, 1, 8'hFF, 64'h0, 1);
    expectWb("b2b_sd", 1'b0, 5'd4, 1'b0, 64'h0, 1'b0);
    applyStimulus("b2b_sd", SD, 0, 1, 64'hE000, 64'h11223344_55667788, 64'h0, 1, 5'd4, 2);
    expectWb("b2b_alu1", 1'b1, 5'd6, 1'b1, 64'h2222, 1'b0);
    applyStimulus("b2b_alu1", '0, 0, 0, 64'h0, 64'h0, 64'h2222, 1, 5'd6, 1);

    // Reset in REQ: the pending load is dropped and a late ack is ignored.
    expectReq("rst_ld", 64'hB000, 0, 64'h0, 0, 8'h00, 64'hFFFF, 50);
    applyStimulus("rst_ld", LD, 1, 0, 64'hB000, 64'h0, 64'h0, 1, 5'd18, -1);
    repeat (2) @(negedge clk);
    checkOutput("rst_ld.req_before_rst", o_dmem_req, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("rst_ld.req_in_rst", o_dmem_req, 1'b0);
    checkOutput("rst_ld.ready_in_rst", o_ready, 1'b1);
    checkOutput("rst_ld.valid_in_rst", o_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 inject_ack = 1'b1;
    @(posedge clk);
    #1 inject_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_ld.valid_after_ack", o_valid, 1'b0);
      checkOutput("rst_ld.ready_after_ack", o_ready, 1'b1);
      checkOutput("rst_ld.req_after_ack", o_dmem_req, 1'b0);
    end

    repeat (5) @(negedge clk);
    checkOutput("end.wb_queue_empty", 64'(wb_q.size()), 64'd0);
    checkOutput("end.req_queue_empty", 64'(req_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             num_checks, num_fails);
    $finish;
  end

endmodule
